xo_exec_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle XO-format execute block.
- Accepts one uPOWER XO-format instruction per cycle over a valid/ready handshake and reads operands from an internal NREGS x XLEN register file.
- Executes the instruction, writes rt back, and maintains the XER (SO/OV/CA) and CR0 state that OE and Rc control.
- Sits between decode and the writeback/commit logic of the uPOWER datapath.

---
 rtl/xo_exec_pipe_if.sv | 39 +++
 rtl/xo_exec_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_xo_exec_pipe.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xo_exec_pipe_if.sv
// Instruction, completion, flag and debug signals of the pipelined XO execute block.
// master = decode/testbench side, slave = execute block.
interface xo_exec_pipe_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_po;
    logic [REG_AW-1:0] in_rt;
    logic [REG_AW-1:0] in_ra;
    logic [REG_AW-1:0] in_rb;
    logic              in_oe;
    logic [8:0]        in_xo;
    logic              in_rc;
    logic              out_valid;
    logic              out_ready;
    logic [REG_AW-1:0] out_rt;
    logic [XLEN-1:0]   out_result;
    logic              out_illegal;
    logic              xer_so;
    logic              xer_ov;
    logic              xer_ca;
    logic [3:0]        cr0;
    logic [REG_AW-1:0] dbg_addr;
    logic [XLEN-1:0]   dbg_data;

    modport master (
        output in_valid, in_po, in_rt, in_ra, in_rb, in_oe, in_xo, in_rc, out_ready, dbg_addr,
        input  in_ready, out_valid, out_rt, out_result, out_illegal,
               xer_so, xer_ov, xer_ca, cr0, dbg_data
    );

    modport slave (
        input  in_valid, in_po, in_rt, in_ra, in_rb, in_oe, in_xo, in_rc, out_ready, dbg_addr,
        output in_ready, out_valid, out_rt, out_result, out_illegal,
               xer_so, xer_ov, xer_ca, cr0, dbg_data
    );
endinterface

// File: rtl/xo_exec_pipe.sv
// Two-stage (RD/EX, RES) uPOWER XO-format execute pipeline with internal register
// file, result bypass, and XER/CR0 maintenance.
module xo_exec_pipe #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    xo_exec_pipe_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD, OP_SUBF, OP_NEG, OP_ADDC, OP_SUBFC, OP_ADDE, OP_ILL
    } op_e;

    logic [XLEN-1:0]   regs_q [NREGS];

    logic              ex_valid_q, ex_valid_d;
    op_e               ex_op_q, ex_op_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    logic [XLEN-1:0]   ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic              ex_oe_q, ex_oe_d, ex_rc_q, ex_rc_d;

    logic              out_valid_q, out_valid_d;
    logic [REG_AW-1:0] out_rt_q, out_rt_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic              out_illegal_q, out_illegal_d;
    logic              so_q, so_d, ov_q, ov_d, ca_q, ca_d;
    logic [3:0]        cr0_q, cr0_d;

    op_e               dec_op;
    logic [XLEN-1:0]   add_x, add_y, ex_res;
    logic              add_cin;
    logic [XLEN:0]     add_sum;
    logic              ex_ov, ex_carry, ex_ill, ex_wr_ca;
    logic              stall, step, wr_en, in_ready, accept;
    logic              fwd_a, fwd_b;
    logic [XLEN-1:0]   opnd_a, opnd_b;

    always_comb begin
        dec_op = OP_ILL;
        if (bus.in_po == 6'd31) begin
            case (bus.in_xo)
                9'd266:  dec_op = OP_ADD;
                9'd40:   dec_op = OP_SUBF;
                9'd104:  dec_op = OP_NEG;
                9'd10:   dec_op = OP_ADDC;
                9'd8:    dec_op = OP_SUBFC;
                9'd138:  dec_op = OP_ADDE;
                default: dec_op = OP_ILL;
            endcase
        end
    end

    // Every op maps onto x + y + cin; subtraction uses ~ra + 1, so signed overflow
    // is always "operands agree in sign, result disagrees".
    always_comb begin
        add_x   = ex_a_q;
        add_y   = ex_b_q;
        add_cin = 1'b0;
        case (ex_op_q)
            OP_SUBF, OP_SUBFC: begin
                add_x   = ~ex_a_q;
                add_cin = 1'b1;
            end
            OP_NEG: begin
                add_x   = ~ex_a_q;
                add_y   = '0;
                add_cin = 1'b1;
            end
            OP_ADDE: add_cin = ca_q;
            default: ;
        endcase
    end

    assign add_sum  = {1'b0, add_x} + {1'b0, add_y} + {{XLEN{1'b0}}, add_cin};
    assign ex_res   = add_sum[XLEN-1:0];
    assign ex_carry = add_sum[XLEN];
    assign ex_ov    = (add_x[XLEN-1] == add_y[XLEN-1]) && (ex_res[XLEN-1] != add_x[XLEN-1]);
    assign ex_ill   = (ex_op_q == OP_ILL);
    assign ex_wr_ca = (ex_op_q == OP_ADDC) || (ex_op_q == OP_SUBFC) || (ex_op_q == OP_ADDE);

    assign stall    = out_valid_q & ~bus.out_ready;
    assign step     = ex_valid_q & ~stall;
    assign wr_en    = step & ~ex_ill;
    assign in_ready = ~(ex_valid_q & stall);
    assign accept   = bus.in_valid & in_ready;

    // The instruction retiring on this edge has not reached the regfile yet.
    assign fwd_a  = wr_en && (ex_rt_q == bus.in_ra);
    assign fwd_b  = wr_en && (ex_rt_q == bus.in_rb);
    assign opnd_a = fwd_a ? ex_res : regs_q[bus.in_ra];
    assign opnd_b = fwd_b ? ex_res : regs_q[bus.in_rb];

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_op_d       = ex_op_q;
        ex_rt_d       = ex_rt_q;
        ex_a_d        = ex_a_q;
        ex_b_d        = ex_b_q;
        ex_oe_d       = ex_oe_q;
        ex_rc_d       = ex_rc_q;
        out_valid_d   = out_valid_q;
        out_rt_d      = out_rt_q;
        out_result_d  = out_result_q;
        out_illegal_d = out_illegal_q;
        so_d          = so_q;
        ov_d          = ov_q;
        ca_d          = ca_q;
        cr0_d         = cr0_q;

        if (step) begin
            ex_valid_d = 1'b0;
        end
        if (accept) begin
            ex_valid_d = 1'b1;
            ex_op_d    = dec_op;
            ex_rt_d    = bus.in_rt;
            ex_a_d     = opnd_a;
            ex_b_d     = opnd_b;
            ex_oe_d    = bus.in_oe;
            ex_rc_d    = bus.in_rc;
        end

        if (!stall) begin
            out_valid_d = ex_valid_q;
            if (ex_valid_q) begin
                out_rt_d      = ex_rt_q;
                out_result_d  = ex_ill ? '0 : ex_res;
                out_illegal_d = ex_ill;
            end
        end

        if (wr_en) begin
            if (ex_oe_q) begin
                ov_d = ex_ov;
                so_d = so_q | ex_ov;
            end
            if (ex_wr_ca) begin
                ca_d = ex_carry;
            end
            if (ex_rc_q) begin
                cr0_d = {ex_res[XLEN-1], ~ex_res[XLEN-1] & (|ex_res), ~(|ex_res), so_d};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= XLEN'(i);
            end
        end else if (wr_en) begin
            regs_q[ex_rt_q] <= ex_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_op_q       <= OP_ILL;
            ex_rt_q       <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_oe_q       <= 1'b0;
            ex_rc_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_rt_q      <= '0;
            out_result_q  <= '0;
            out_illegal_q <= 1'b0;
            so_q          <= 1'b0;
            ov_q          <= 1'b0;
            ca_q          <= 1'b0;
            cr0_q         <= 4'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_op_q       <= ex_op_d;
            ex_rt_q       <= ex_rt_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_oe_q       <= ex_oe_d;
            ex_rc_q       <= ex_rc_d;
            out_valid_q   <= out_valid_d;
            out_rt_q      <= out_rt_d;
            out_result_q  <= out_result_d;
            out_illegal_q <= out_illegal_d;
            so_q          <= so_d;
            ov_q          <= ov_d;
            ca_q          <= ca_d;
            cr0_q         <= cr0_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_rt      = out_rt_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_illegal = out_illegal_q;
    assign bus.xer_so      = so_q;
    assign bus.xer_ov      = ov_q;
    assign bus.xer_ca      = ca_q;
    assign bus.cr0         = cr0_q;
    assign bus.dbg_data    = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_xo_exec_pipe.sv
// Scoreboard bench for xo_exec_pipe: a reference model predicts each completion at
// accept time; completions are popped and compared as the pipeline hands them out.
module tb_xo_exec_pipe;
    localparam logic [8:0]  XO_ADD = 9'd266, XO_SUBF = 9'd40, XO_NEG = 9'd104;
    localparam logic [8:0]  XO_ADDC = 9'd10, XO_SUBFC = 9'd8, XO_ADDE = 9'd138;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [4:0]  rt;
        logic [63:0] res;
        logic        ill;
        logic        so, ov, ca;
        logic [3:0]  cr0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic man_rdy = 1'b1;
    logic rand_rdy = 1'b1;
    logic rand_en = 1'b0;

    xo_exec_pipe_if #(.XLEN(64), .REG_AW(5)) ifc ();

    xo_exec_pipe #(.XLEN(64), .NREGS(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    assign ifc.out_ready = rand_en ? rand_rdy : man_rdy;

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [63:0] m_reg [32];
    logic        m_so, m_ov, m_ca;
    logic [3:0]  m_cr0;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 64'(i);
        m_so = 0; m_ov = 0; m_ca = 0; m_cr0 = 4'b0;
    endtask

    task automatic model_step(input logic [5:0] po, input int rt, input int ra, input int rb,
                              input logic oe, input logic [8:0] xo, input logic rc);
        logic [63:0] a, b, r;
        logic [64:0] w;
        logic        ov, cnew, legal, wca;
        exp_t        e;
        a = m_reg[ra]; b = m_reg[rb];
        legal = (po == 6'd31); wca = 0; ov = 0; r = 0; cnew = 0;
        if (legal) begin
            case (xo)
                XO_ADD:   begin r = a + b; ov = (a[63] == b[63]) && (r[63] != a[63]); end
                XO_SUBF:  begin r = b - a; ov = (a[63] != b[63]) && (r[63] != b[63]); end
                XO_NEG:   begin r = -a; ov = (a == MINV); end
                XO_ADDC:  begin
                    w = {1'b0, a} + {1'b0, b}; r = w[63:0]; cnew = w[64]; wca = 1;
                    ov = (a[63] == b[63]) && (r[63] != a[63]);
                end
                XO_SUBFC: begin
                    w = {1'b0, b} + {1'b0, ~a} + 65'd1; r = w[63:0]; cnew = w[64]; wca = 1;
                    ov = (a[63] != b[63]) && (r[63] != b[63]);
                end
                XO_ADDE:  begin
                    w = {1'b0, a} + {1'b0, b} + {64'd0, m_ca}; r = w[63:0]; cnew = w[64]; wca = 1;
                    ov = (a[63] == b[63]) && (r[63] != a[63]);
                end
                default: legal = 0;
            endcase
        end
        if (legal) begin
            m_reg[rt] = r;
            if (oe) begin m_ov = ov; m_so = m_so | ov; end
            if (wca) m_ca = cnew;
            if (rc) m_cr0 = {r[63], !r[63] && (r != 0), r == 0, m_so};
        end else begin
            r = 0;
        end
        e.rt = 5'(rt); e.res = r; e.ill = !legal;
        e.so = m_so; e.ov = m_ov; e.ca = m_ca; e.cr0 = m_cr0;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic issue(input logic [5:0] po, input int rt, input int ra, input int rb,
                         input logic oe, input logic [8:0] xo, input logic rc);
        bit done = 0;
        int guard = 0;
        ifc.in_valid = 1; ifc.in_po = po;
        ifc.in_rt = 5'(rt); ifc.in_ra = 5'(ra); ifc.in_rb = 5'(rb);
        ifc.in_oe = oe; ifc.in_xo = xo; ifc.in_rc = rc;
        while (!done && guard < 500) begin
            @(negedge clk);
            done = ifc.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        ifc.in_valid = 0;
        if (done) model_step(po, rt, ra, rb, oe, xo, rc);
        else check("accept_timeout", 64'(ifc.in_ready), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic reg_chk(input string tag, input int idx, input logic [63:0] want);
        ifc.dbg_addr = 5'(idx);
        #1;
        check(tag, ifc.dbg_data, want);
    endtask

    always @(negedge clk) begin
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(ifc.out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("[%0t] done rt=%0d res=%h ill=%b so=%b ov=%b ca=%b cr0=%b", $time,
                         ifc.out_rt, ifc.out_result, ifc.out_illegal,
                         ifc.xer_so, ifc.xer_ov, ifc.xer_ca, ifc.cr0);
                check("out_rt", 64'(ifc.out_rt), 64'(e.rt));
                check("out_result", ifc.out_result, e.res);
                check("out_illegal", 64'(ifc.out_illegal), 64'(e.ill));
                check("xer_so", 64'(ifc.xer_so), 64'(e.so));
                check("xer_ov", 64'(ifc.xer_ov), 64'(e.ov));
                check("xer_ca", 64'(ifc.xer_ca), 64'(e.ca));
                check("cr0", 64'(ifc.cr0), 64'(e.cr0));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rand_rdy = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] xos [7];
        xos[0] = XO_ADD; xos[1] = XO_SUBF; xos[2] = XO_NEG; xos[3] = XO_ADDC;
        xos[4] = XO_SUBFC; xos[5] = XO_ADDE; xos[6] = 9'd200;
        ifc.in_valid = 0; ifc.in_po = 0; ifc.in_rt = 0; ifc.in_ra = 0; ifc.in_rb = 0;
        ifc.in_oe = 0; ifc.in_xo = 0; ifc.in_rc = 0; ifc.dbg_addr = 0;
        model_reset();

        #1;
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_out_result", ifc.out_result, 64'd0);
        check("rst_out_rt", 64'(ifc.out_rt), 64'd0);
        check("rst_flags", 64'({ifc.xer_so, ifc.xer_ov, ifc.xer_ca, ifc.out_illegal}), 64'd0);
        check("rst_cr0", 64'(ifc.cr0), 64'd0);
        #20 rst = 0;
        #1;
        check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        for (int i = 0; i < 32; i++) reg_chk("rst_reg", i, 64'(i));
        @(posedge clk); #1;

        // Latency: result visible two edges after accept.
        issue(6'd31, 3, 5, 7, 0, XO_ADD, 1);
        check("lat_edge1_valid", 64'(ifc.out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge2_valid", 64'(ifc.out_valid), 64'd1);
        check("lat_result", ifc.out_result, 64'd12);
        check("lat_cr0", 64'(ifc.cr0), 64'b0100);
        reg_chk("lat_reg3", 3, 64'd12);
        drain();

        // Back-to-back dependency through the bypass.
        issue(6'd31, 1, 2, 3, 0, XO_ADD, 0);
        issue(6'd31, 4, 1, 1, 0, XO_ADD, 0);
        drain();
        reg_chk("bypass_r4", 4, 64'd28);

        // Build MIN by doubling 1, then MAX = MIN - 1.
        issue(6'd31, 20, 21, 22, 0, XO_SUBF, 0);
        issue(6'd31, 24, 22, 23, 0, XO_SUBF, 0);
        for (int i = 0; i < 63; i++) issue(6'd31, 20, 20, 20, 0, XO_ADD, 0);
        issue(6'd31, 5, 24, 20, 0, XO_SUBF, 0);
        drain();
        reg_chk("min_r20", 20, MINV);
        reg_chk("max_r5", 5, 64'h7FFF_FFFF_FFFF_FFFF);
        check("oe0_keeps_so", 64'(ifc.xer_so), 64'd0);

        issue(6'd31, 6, 5, 24, 1, XO_ADD, 1);
        drain();
        reg_chk("ovf_r6", 6, MINV);
        check("ovf_ov", 64'(ifc.xer_ov), 64'd1);
        check("ovf_so", 64'(ifc.xer_so), 64'd1);
        check("ovf_cr0", 64'(ifc.cr0), 64'b1001);
        issue(6'd31, 7, 24, 24, 1, XO_ADD, 0);
        drain();
        check("noovf_ov", 64'(ifc.xer_ov), 64'd0);
        check("sticky_so", 64'(ifc.xer_so), 64'd1);
        check("rc0_cr0_kept", 64'(ifc.cr0), 64'b1001);
        issue(6'd31, 21, 20, 0, 1, XO_NEG, 1);
        drain();
        check("neg_min_ov", 64'(ifc.xer_ov), 64'd1);

        // Carry chain: addc then back-to-back adde consuming the new CA.
        issue(6'd31, 25, 24, 0, 0, XO_NEG, 0);
        issue(6'd31, 30, 24, 2, 0, XO_ADD, 0);
        issue(6'd31, 27, 25, 24, 0, XO_ADDC, 0);
        issue(6'd31, 28, 2, 30, 0, XO_ADDE, 0);
        drain();
        reg_chk("addc_r27", 27, 64'd0);
        reg_chk("adde_r28", 28, 64'd6);
        check("adde_ca", 64'(ifc.xer_ca), 64'd0);
        issue(6'd31, 13, 24, 2, 0, XO_SUBFC, 0);
        issue(6'd31, 14, 2, 24, 0, XO_SUBFC, 1);
        drain();
        reg_chk("subfc_r14", 14, 64'hFFFF_FFFF_FFFF_FFFF);

        // Stall with two in flight.
        man_rdy = 0;
        issue(6'd31, 8, 2, 2, 0, XO_ADD, 0);
        issue(6'd31, 9, 24, 24, 0, XO_ADD, 0);
        check("stall_in_ready", 64'(ifc.in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("stall_valid", 64'(ifc.out_valid), 64'd1);
        check("stall_rt", 64'(ifc.out_rt), 64'd8);
        check("stall_result", ifc.out_result, 64'd4);
        reg_chk("stall_r9_unwritten", 9, 64'd9);
        man_rdy = 1;
        drain();
        reg_chk("drain_r9", 9, 64'd2);

        // Illegal: wrong po, then unlisted xo.
        issue(6'd30, 10, 2, 3, 1, XO_ADD, 1);
        issue(6'd31, 10, 2, 3, 1, 9'd100, 1);
        drain();
        reg_chk("illegal_r10", 10, 64'd10);

        // Random mix with random out_ready back-pressure.
        rand_en = 1;
        for (int i = 0; i < 60; i++) begin
            issue(($urandom_range(0, 9) == 0) ? 6'd30 : 6'd31,
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  xos[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
        end
        drain();
        rand_en = 0;

        // Reset while stalled.
        man_rdy = 0;
        issue(6'd31, 11, 2, 2, 0, XO_ADD, 0);
        issue(6'd31, 12, 2, 2, 0, XO_ADD, 0);
        ifc.dbg_addr = 5'd11;
        #2 rst = 1;
        #1;
        check("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("midrst_r11", ifc.dbg_data, 64'd11);
        check("midrst_so", 64'(ifc.xer_so), 64'd0);
        exp_q.delete();
        model_reset();
        #3 rst = 0;
        @(posedge clk); #1;
        man_rdy = 1;
        issue(6'd31, 3, 5, 7, 0, XO_ADD, 1);
        drain();
        reg_chk("post_rst_r3", 3, 64'd12);
        reg_chk("post_rst_r12", 12, 64'd12);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
